// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage. Drives the PC onto the combinational
//             instruction-memory address, captures the returned word and queues
//             {instr, pc} in a 2-entry buffer presented to decode over a
//             valid/ready handshake. Supports redirect with flush, fetch
//             enable and a wrapping fetched-instruction counter.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             : clock, all state updates on rising edge
//    rst_n           : asynchronous active-low reset
//    i_address       : byte address to instruction memory (== PC register)
//    instruction     : word returned combinationally for i_address
//    fetch_en        : 1 = new fetches permitted; queue drains regardless
//    redirect_valid  : branch/jump taken, flush queue and load new PC
//    redirect_target : new PC, bits [1:0] forced to zero
//    out_valid       : queue head holds a valid instruction
//    out_ready       : decode accepts the head this cycle
//    out_instr       : head instruction word (0 when empty)
//    out_pc          : PC of head instruction (0 when empty)
//    fetch_count     : number of words pushed since reset, wraps
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] i_address,
    input  logic [31:0]       instruction,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [CNT_W-1:0]  fetch_count
);

    localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(4);
    localparam logic [1:0]        C_DEPTH   = 2'd2;

    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_fetch_count;
    logic [1:0]        r_count;
    logic              r_head;
    logic              r_tail;
    logic [31:0]       r_q_instr [2];
    logic [ADDR_W-1:0] r_q_pc    [2];

    logic w_pop;
    logic w_push;

    // A pop frees a slot in the same cycle, so a full queue can still accept
    // a new word when decode is consuming the head.
    assign w_pop  = out_valid & out_ready;
    assign w_push = fetch_en & ~redirect_valid & ((r_count < C_DEPTH) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
            r_count       <= 2'd0;
            r_head        <= 1'b0;
            r_tail        <= 1'b0;
            r_q_instr[0]  <= '0;
            r_q_instr[1]  <= '0;
            r_q_pc[0]     <= '0;
            r_q_pc[1]     <= '0;
        end else if (redirect_valid) begin
            // Flush: any same-cycle pop has already been handed to decode,
            // so dropping every entry here is safe.
            r_pc    <= {redirect_target[ADDR_W-1:2], 2'b00};
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            if (w_push) begin
                r_q_instr[r_tail] <= instruction;
                r_q_pc[r_tail]    <= r_pc;
                r_tail            <= ~r_tail;
                r_pc              <= r_pc + C_PC_STEP;
                r_fetch_count     <= r_fetch_count + CNT_W'(1);
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign i_address   = r_pc;
    assign fetch_count = r_fetch_count;
    assign out_valid   = (r_count != 2'd0);
    assign out_instr   = out_valid ? r_q_instr[r_head] : 32'd0;
    assign out_pc      = out_valid ? r_q_pc[r_head]    : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. A queue-based reference
//             model tracks PC, buffered {instr, pc} entries and the fetch
//             counter; every cycle the DUT outputs are compared against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 6;   // small counter so wrap-around is reached

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] i_address;
    logic [31:0]       instruction;
    logic              fetch_en;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [CNT_W-1:0]  fetch_count;

    logic [31:0] mem [64];

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (8'h00),
        .CNT_W    (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_address       (i_address),
        .instruction     (instruction),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .fetch_count     (fetch_count)
    );

    assign instruction = mem[i_address[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
    } ent_t;

    ent_t              q[$];
    logic [ADDR_W-1:0] m_pc;
    logic [CNT_W-1:0]  m_fc;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = 8'h00;
        m_fc = '0;
    endtask

    task automatic check_outputs();
        logic [31:0]       e_instr;
        logic [ADDR_W-1:0] e_pc;
        e_instr = (q.size() > 0) ? q[0].instr : 32'd0;
        e_pc    = (q.size() > 0) ? q[0].pc    : 8'd0;
        chk("out_valid",   32'(out_valid),   32'(q.size() > 0));
        chk("out_instr",   out_instr,        e_instr);
        chk("out_pc",      32'(out_pc),      32'(e_pc));
        chk("i_address",   32'(i_address),   32'(m_pc));
        chk("fetch_count", 32'(fetch_count), 32'(m_fc));
    endtask

    // One clock cycle: drive inputs, check the pre-edge outputs, advance the
    // model by the rules of the handshake, then let the edge happen.
    task automatic cyc(input logic fe, input logic rdy, input logic rv, input logic [7:0] tgt);
        logic pop;
        logic push;
        logic [7:0] p;
        fetch_en        = fe;
        out_ready       = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        #1;
        check_outputs();
        pop  = (q.size() > 0) && rdy;
        push = fe && !rv && ((q.size() < 2) || pop);
        if (rv) begin
            q.delete();
            m_pc = tgt & 8'hFC;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                p = m_pc;
                q.push_back('{mem[p[7:2]], p});
                m_pc = m_pc + 8'd4;
                m_fc = m_fc + 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        fetch_en        = 1'b0;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        foreach (mem[i]) mem[i] = $urandom;
        model_reset();

        // Reset state
        #2;
        chk("rst_out_valid",   32'(out_valid),   32'd0);
        chk("rst_out_instr",   out_instr,        32'd0);
        chk("rst_out_pc",      32'(out_pc),      32'd0);
        chk("rst_i_address",   32'(i_address),   32'd0);
        chk("rst_fetch_count", 32'(fetch_count), 32'd0);
        #5 rst_n = 1'b1;

        // 1. Streaming fetch, one instruction per cycle
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00);
        chk("stream_pc_head", 32'(out_pc), 32'd20);

        // 2. Backpressure then release
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("bp_i_address", 32'(i_address), 32'd8);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00);

        // 3. Redirect while full
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b1, 8'h43);
        chk("redir_pc", 32'(i_address), 32'h40);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00);

        // 4. PC wrap 252 -> 0
        cyc(1'b1, 1'b1, 1'b1, 8'hFC);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00);

        // 5. Fetch disabled while full: drain, freeze, resume
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00);

        // 6. Asynchronous reset mid-cycle with a full queue
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid",   32'(out_valid),   32'd0);
        chk("arst_i_address",   32'(i_address),   32'd0);
        chk("arst_fetch_count", 32'(fetch_count), 32'd0);
        chk("arst_out_pc",      32'(out_pc),      32'd0);
        model_reset();
        rst_n = 1'b1;

        // Randomized traffic, long enough to wrap the fetch counter
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 7) != 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 15) == 0),
                8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
